// File: rtl/hex_display_pkg.sv
// Shared types, constants and the nibble-to-glyph table for the HEX display controller.
package hex_display_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SCROLL = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    S_STATIC,
    S_BLINK,
    S_SCROLL
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyph for one hex nibble; bit7 (DP) is returned unlit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_controller_encoder.sv
// One seven-segment digit: glyph lookup, optional blanking, and the decimal point.
module hex_digit_encoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  // A blanked digit still lights its DP, so the DP bit is applied after blanking.
  always_comb begin
    glyph = hex_to_seg(nibble);
    seg   = (blank ? SEG_BLANK : glyph) & ~{dp, 7'b0};
  end

endmodule

// File: rtl/hex_display_controller.sv
// N-digit seven-segment controller with static, blink and scroll-in display modes.
module hex_display_controller
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int TICK_DIV = 25_000_000,
  parameter int LZB      = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_value,
  input  logic [1:0]            load_mode,
  input  logic [N_DIGITS-1:0]   load_dp,
  output logic                  busy,
  output logic [8*N_DIGITS-1:0] HEX
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_DIGITS - 1);

  state_t                  state;
  state_t                  state_n;
  logic [4*N_DIGITS-1:0]   value_q;
  logic [N_DIGITS-1:0]     dp_q;
  logic [PW-1:0]           presc;
  logic                    phase_on;
  logic [CW-1:0]           scroll_cnt;
  logic                    loaded;
  logic [8*N_DIGITS-1:0]   hex_q;

  logic                    load_acc;
  logic                    tick;
  logic [4*N_DIGITS-1:0]   nib_disp;
  logic [N_DIGITS-1:0]     dp_disp;
  logic [N_DIGITS-1:0]     shown;
  logic [N_DIGITS-1:0]     blank;
  logic                    lead_zero;
  logic [8*N_DIGITS-1:0]   seg_next;

  assign busy       = (state == S_SCROLL);
  assign load_ready = ~busy;
  assign load_acc   = load_valid & load_ready;
  assign tick       = (presc == TICK_MAX);
  assign HEX        = hex_q;

  // State register; reset aborts any blink or scroll in progress.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= S_STATIC;
    else          state <= state_n;
  end

  // Next state: loads pick the mode, scroll finishes on the tick that shifts in the last digit.
  always_comb begin
    state_n = state;
    case (state)
      S_STATIC, S_BLINK: begin
        if (load_acc) begin
          case (mode_t'(load_mode))
            MODE_BLINK:  state_n = S_BLINK;
            MODE_SCROLL: state_n = S_SCROLL;
            default:     state_n = S_STATIC;
          endcase
        end
      end
      S_SCROLL: begin
        if (tick && scroll_cnt == CNT_LAST) state_n = S_STATIC;
      end
      default: state_n = S_STATIC;
    endcase
  end

  // Captured load, prescaler, blink phase and scroll position; a load wins over a tick.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      value_q    <= '0;
      dp_q       <= '0;
      presc      <= '0;
      phase_on   <= 1'b1;
      scroll_cnt <= '0;
      loaded     <= 1'b0;
    end else begin
      if (load_acc || tick) presc <= '0;
      else                  presc <= presc + 1'b1;
      if (load_acc) begin
        value_q    <= load_value;
        dp_q       <= load_dp;
        phase_on   <= 1'b1;
        scroll_cnt <= '0;
        loaded     <= 1'b1;
      end else begin
        if (state == S_BLINK && tick)  phase_on   <= ~phase_on;
        if (state == S_SCROLL && tick) scroll_cnt <= scroll_cnt + 1'b1;
      end
    end
  end

  // During scroll the top scroll_cnt nibbles (and their DPs) sit at the low digits; the rest are empty.
  always_comb begin
    nib_disp = value_q;
    dp_disp  = dp_q;
    shown    = '1;
    if (state == S_SCROLL) begin
      nib_disp = value_q >> (4 * (N_DIGITS - int'(scroll_cnt)));
      dp_disp  = dp_q >> (N_DIGITS - int'(scroll_cnt));
      for (int i = 0; i < N_DIGITS; i++) shown[i] = (i < int'(scroll_cnt));
    end
  end

  // Leading-zero blanking walks down from the top digit until the first non-zero nibble.
  always_comb begin
    lead_zero = (LZB != 0);
    blank     = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (nib_disp[4*i +: 4] != 4'h0) lead_zero = 1'b0;
      blank[i] = lead_zero | ~shown[i];
    end
    blank[0] = ~shown[0];
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    hex_digit_encoder u_enc (
      .nibble (nib_disp[4*g +: 4]),
      .dp     (dp_disp[g]),
      .blank  (blank[g]),
      .seg    (seg_next[8*g +: 8])
    );
  end

  // Registered segment outputs; dark until the first load and during the blink OFF phase.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N)                                    hex_q <= '1;
    else if (!loaded || (state == S_BLINK && !phase_on)) hex_q <= '1;
    else                                             hex_q <= seg_next;
  end

endmodule
